// File: rtl/clock_pkg.sv
// clock_pkg: shared time-of-day types and constants for the alarm logic
package clock_pkg;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_e;
  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR = 60;
  localparam int SEC_PER_MIN = 60;
  typedef struct packed {
    logic [5:0] hr;
    logic [5:0] min;
  } hhmm_t;
  function automatic logic hhmm_valid(hhmm_t t);
    return t.hr < 6'(HOURS_PER_DAY) && t.min < 6'(MIN_PER_HOUR);
  endfunction
endpackage

// File: rtl/time_add_min.sv
// time_add_min: combinational hh:mm + add_min (< 60) with minute and hour wrap
module time_add_min
  import clock_pkg::*;
(
  input  hhmm_t      t_in,
  input  logic [5:0] add_min,
  output hhmm_t      t_out
);
  logic [6:0] min_sum;
  logic       carry;
  logic [5:0] hr_sum;
  // a single carry into the hour is enough because add_min stays below one hour
  always_comb begin
    min_sum = {1'b0, t_in.min} + {1'b0, add_min};
    carry = min_sum >= 7'(MIN_PER_HOUR);
    t_out.min = carry ? 6'(min_sum - 7'(MIN_PER_HOUR)) : min_sum[5:0];
    hr_sum = t_in.hr + {5'b0, carry};
    t_out.hr = hr_sum >= 6'(HOURS_PER_DAY) ? hr_sum - 6'(HOURS_PER_DAY) : hr_sum;
  end
endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm ring/snooze/dismiss FSM; ALARM_AUTO_SNOOZE_EN turns ring timeout into a snooze
module alarm_trigger
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [5:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [5:0] alm_hr,
  input  logic [5:0] alm_min,
  input  logic       alm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       ringing,
  output logic       buzzer,
  output logic       snoozed,
  output logic [1:0] snooze_cnt
);
  state_e     state_q, state_d;
  logic       buzzer_q, buzzer_d;
  logic       ringing_q, snoozed_q;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] tmr_q, tmr_d;
  hhmm_t      tgt_q, tgt_d;
  logic       snz_prev_q, dis_prev_q;
  hhmm_t      cur, alm, snz_next;
  logic       snz_edge, dis_edge, at_min, alm_hit, snz_hit, can_snz, timeout, auto_snz;
  logic [7:0] tmr_inc;
  assign cur = {cur_hr, cur_min};
  assign alm = {alm_hr, alm_min};
  assign snz_edge = snooze & ~snz_prev_q;
  assign dis_edge = dismiss & ~dis_prev_q;
  assign at_min = sec_tick && cur_sec == 6'd0;
  assign alm_hit = at_min && hhmm_valid(alm) && cur == alm;
  assign snz_hit = at_min && cur == tgt_q;
  assign can_snz = cnt_q < 2'(MAX_SNOOZE);
  assign tmr_inc = tmr_q + 8'd1;
  assign timeout = sec_tick && tmr_inc == 8'(RING_TIMEOUT_S);
`ifdef ALARM_AUTO_SNOOZE_EN
  assign auto_snz = timeout;
`else
  assign auto_snz = 1'b0;
`endif
  time_add_min u_add (
    .t_in   (cur),
    .add_min(6'(SNOOZE_MIN)),
    .t_out  (snz_next)
  );
  // next state in priority order: disable, dismiss, snooze, timeout, match
  always_comb begin
    state_d = state_q;
    buzzer_d = buzzer_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    tgt_d = tgt_q;
    if (!alm_en) begin
      state_d = IDLE;
      buzzer_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (alm_hit) begin
          state_d = RINGING;
          buzzer_d = 1'b1;
          tmr_d = 8'd0;
          cnt_d = 2'd0;
        end
        RINGING: if (dis_edge) begin
          state_d = IDLE;
          buzzer_d = 1'b0;
        end else if ((snz_edge || auto_snz) && can_snz) begin
          state_d = SNOOZED;
          buzzer_d = 1'b0;
          tgt_d = snz_next;
          cnt_d = cnt_q + 2'd1;
        end else if (timeout) begin
          state_d = IDLE;
          buzzer_d = 1'b0;
        end else if (sec_tick) begin
          tmr_d = tmr_inc;
          buzzer_d = ~buzzer_q;
        end
        SNOOZED: if (dis_edge) begin
          state_d = IDLE;
        end else if (snz_hit) begin
          state_d = RINGING;
          buzzer_d = 1'b1;
          tmr_d = 8'd0;
        end
        default: begin
          state_d = IDLE;
          buzzer_d = 1'b0;
        end
      endcase
    end
  end
  // state, outputs and button history; reset drops the buzzer immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buzzer_q <= 1'b0;
      ringing_q <= 1'b0;
      snoozed_q <= 1'b0;
      cnt_q <= 2'd0;
      tmr_q <= 8'd0;
      tgt_q <= '0;
      snz_prev_q <= 1'b0;
      dis_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buzzer_q <= buzzer_d;
      ringing_q <= state_d == RINGING;
      snoozed_q <= state_d == SNOOZED;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      tgt_q <= tgt_d;
      snz_prev_q <= snooze;
      dis_prev_q <= dismiss;
    end
  end
  assign ringing = ringing_q;
  assign buzzer = buzzer_q;
  assign snoozed = snoozed_q;
  assign snooze_cnt = cnt_q;
endmodule
